// File: rtl/dht11_data_reader.sv
// DHT11 40-bit frame receiver: decodes bits by high-pulse width after the
// start/response handshake, verifies the checksum and latches the readings.
module dht11_data_reader #(
    parameter int BIT_THRESHOLD = 40,
    parameter int TIMEOUT_CYC   = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       data_in,
    output logic [7:0] hum_int,
    output logic [7:0] hum_dec,
    output logic [7:0] temp_int,
    output logic [7:0] temp_dec,
    output logic       data_valid,
    output logic       checksum_err,
    output logic       timeout_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH,
        MEASURE,
        CHECK
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYC);
    localparam logic [15:0] THRESH      = 16'(BIT_THRESHOLD);

    logic        sync1_q, sync2_q;
    logic        start_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [39:0] shift_q, shift_d;
    logic [7:0]  hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
    logic [7:0]  temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;
    logic        data_valid_q, data_valid_d;
    logic        checksum_err_q, checksum_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic        busy_q, busy_d;

    logic        data_sync;
    logic        arm;
    logic        timed_out;
    logic [7:0]  sum;

    assign data_sync = sync2_q;
    assign arm       = start & ~start_q;
    assign timed_out = (cnt_q >= TIMEOUT_LIM);
    assign sum       = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        hum_int_d      = hum_int_q;
        hum_dec_d      = hum_dec_q;
        temp_int_d     = temp_int_q;
        temp_dec_d     = temp_dec_q;
        data_valid_d   = 1'b0;
        checksum_err_d = 1'b0;
        timeout_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d   = WAIT_LOW;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            WAIT_LOW: begin
                cnt_d = cnt_q + 16'd1;
                if (timed_out) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (!data_sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                cnt_d = cnt_q + 16'd1;
                if (timed_out) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (data_sync) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end
            end
            MEASURE: begin
                // Timeout takes priority so a stuck-high line always aborts.
                if (timed_out) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else if (data_sync) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    shift_d   = {shift_q[38:0], (cnt_q > THRESH)};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    cnt_d     = '0;
                    state_d   = (bit_cnt_q == 6'd39) ? CHECK : WAIT_HIGH;
                end
            end
            CHECK: begin
                if (sum == shift_q[7:0]) begin
                    hum_int_d    = shift_q[39:32];
                    hum_dec_d    = shift_q[31:24];
                    temp_int_d   = shift_q[23:16];
                    temp_dec_d   = shift_q[15:8];
                    data_valid_d = 1'b1;
                end else begin
                    checksum_err_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            start_q        <= 1'b0;
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            hum_int_q      <= '0;
            hum_dec_q      <= '0;
            temp_int_q     <= '0;
            temp_dec_q     <= '0;
            data_valid_q   <= 1'b0;
            checksum_err_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync1_q        <= data_in;
            sync2_q        <= sync1_q;
            start_q        <= start;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            hum_int_q      <= hum_int_d;
            hum_dec_q      <= hum_dec_d;
            temp_int_q     <= temp_int_d;
            temp_dec_q     <= temp_dec_d;
            data_valid_q   <= data_valid_d;
            checksum_err_q <= checksum_err_d;
            timeout_err_q  <= timeout_err_d;
            busy_q         <= busy_d;
        end
    end

    assign hum_int      = hum_int_q;
    assign hum_dec      = hum_dec_q;
    assign temp_int     = temp_int_q;
    assign temp_dec     = temp_dec_q;
    assign data_valid   = data_valid_q;
    assign checksum_err = checksum_err_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = busy_q;

endmodule
